// File: rtl/nano_sysbus.sv
// nano_sysbus: word-addressed bus slave for the nano2 stack CPU.
// Decodes the CPU port onto on-chip RAM and one interval timer, and drives the
// CPU irq input from the timer's expiry flag.
//
// Handshake: a request (read or write) is accepted in the cycle where it is
// high and waitrequest is 0. Writes are accepted at once. Reads stall for
// exactly one cycle: cycle 1 samples the RAM/register and raises ack, and
// cycle 2 presents readdata with waitrequest low. read and write together
// count as a write only.
module nano_sysbus #(
    parameter int WIDTHA   = 12,
    parameter int WIDTHD   = 32,
    parameter int RAMWORDS = 2048,
    parameter     INITFILE = ""
) (
    input  logic              clock,
    input  logic              sreset,
    input  logic [WIDTHA-1:0] address,
    input  logic [WIDTHD-1:0] writedata,
    input  logic              read,
    input  logic              write,
    output logic [WIDTHD-1:0] readdata,
    output logic              waitrequest,
    output logic              irq
);

    localparam int              RAW       = $clog2(RAMWORDS);
    localparam logic [WIDTHA:0] RAM_LIMIT = (WIDTHA+1)'(RAMWORDS);
    localparam logic [WIDTHA-1:0] A_CTRL   = WIDTHA'('hF00);
    localparam logic [WIDTHA-1:0] A_RELOAD = WIDTHA'('hF01);
    localparam logic [WIDTHA-1:0] A_COUNT  = WIDTHA'('hF02);
    localparam logic [WIDTHA-1:0] A_STATUS = WIDTHA'('hF03);

    // Handshake and read-path state.
    logic              r_ack;
    logic              r_rd_ram;
    logic [WIDTHD-1:0] r_ram_q;
    logic [WIDTHD-1:0] r_reg_q;
    logic [WIDTHD-1:0] r_mem [RAMWORDS];

    // Timer state.
    logic              r_en;
    logic              r_ie;
    logic              r_auto;
    logic              r_exp;
    logic              r_irq;
    logic [WIDTHD-1:0] r_reload;
    logic [WIDTHD-1:0] r_count;

    logic              w_rd_issue;
    logic              w_ram_hit;
    logic [RAW-1:0]    w_ram_idx;
    logic              w_wr_ctrl;
    logic              w_wr_reload;
    logic              w_wr_count;
    logic              w_wr_status;
    logic              w_count_zero;
    logic              w_expire;
    logic [WIDTHD-1:0] w_reg_rdata;

    // Cycle 1 of a read: request present, not a write, not yet acknowledged.
    assign w_rd_issue  = read & ~write & ~r_ack;
    assign waitrequest = w_rd_issue;

    assign w_ram_hit   = ({1'b0, address} < RAM_LIMIT);
    assign w_ram_idx   = address[RAW-1:0];

    // Writes never stall, so every write cycle is an accepted write.
    assign w_wr_ctrl   = write & (address == A_CTRL);
    assign w_wr_reload = write & (address == A_RELOAD);
    assign w_wr_count  = write & (address == A_COUNT);
    assign w_wr_status = write & (address == A_STATUS);

    // A COUNT write in the same cycle suppresses the expiry event entirely.
    assign w_count_zero = (r_count == '0);
    assign w_expire     = r_en & w_count_zero & ~w_wr_count;

    // Register-file read mux; unmapped addresses (and RAM hits) read as 0 here.
    always_comb begin
        w_reg_rdata = '0;
        case (address)
            A_CTRL:   w_reg_rdata = {{(WIDTHD-3){1'b0}}, r_auto, r_ie, r_en};
            A_RELOAD: w_reg_rdata = r_reload;
            A_COUNT:  w_reg_rdata = r_count;
            A_STATUS: w_reg_rdata = {{(WIDTHD-1){1'b0}}, r_exp};
            default:  w_reg_rdata = '0;
        endcase
    end

    // Single-port synchronous RAM: write on accepted write, read on cycle 1.
    always_ff @(posedge clock) begin
        if (write && w_ram_hit)
            r_mem[w_ram_idx] <= writedata;
        if (w_rd_issue && w_ram_hit && !sreset)
            r_ram_q <= r_mem[w_ram_idx];
    end

    // Ack toggles for one cycle per read; read-source select and register data
    // are captured in cycle 1 so readdata has no path from address.
    always_ff @(posedge clock) begin
        if (sreset) begin
            r_ack    <= 1'b0;
            r_rd_ram <= 1'b0;
            r_reg_q  <= '0;
        end else begin
            r_ack <= w_rd_issue;
            if (w_rd_issue) begin
                r_rd_ram <= w_ram_hit;
                r_reg_q  <= w_reg_rdata;
            end
        end
    end

    assign readdata = r_rd_ram ? r_ram_q : r_reg_q;

    // Timer registers: COUNT write > expiry/reload > decrement; expiry > EXP clear.
    always_ff @(posedge clock) begin
        if (sreset) begin
            r_en     <= 1'b0;
            r_ie     <= 1'b0;
            r_auto   <= 1'b0;
            r_exp    <= 1'b0;
            r_irq    <= 1'b0;
            r_reload <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_reload)
                r_reload <= writedata;

            if (w_wr_count)
                r_count <= writedata;
            else if (r_en) begin
                if (w_count_zero)
                    r_count <= r_auto ? r_reload : '0;
                else
                    r_count <= r_count - WIDTHD'(1);
            end

            if (w_expire && !r_auto)
                r_en <= 1'b0;
            else if (w_wr_ctrl)
                r_en <= writedata[0];

            if (w_wr_ctrl) begin
                r_ie   <= writedata[1];
                r_auto <= writedata[2];
            end

            if (w_expire)
                r_exp <= 1'b1;
            else if (w_wr_status && writedata[0])
                r_exp <= 1'b0;

            r_irq <= r_exp & r_ie;
        end
    end

    assign irq = r_irq;

endmodule

// File: tb/tb_nano_sysbus.sv
// Directed testbench for nano_sysbus: reset, RAM, decode, handshake and timer.
module tb_nano_sysbus;

    localparam logic [11:0] A_CTRL   = 12'hF00;
    localparam logic [11:0] A_RELOAD = 12'hF01;
    localparam logic [11:0] A_COUNT  = 12'hF02;
    localparam logic [11:0] A_STATUS = 12'hF03;

    logic        clock;
    logic        sreset;
    logic [11:0] address;
    logic [31:0] writedata;
    logic        read;
    logic        write;
    logic [31:0] readdata;
    logic        waitrequest;
    logic        irq;

    int n_tests;
    int n_fail;
    int cyc;
    int c0;

    nano_sysbus #(
        .WIDTHA(12),
        .WIDTHD(32),
        .RAMWORDS(2048),
        .INITFILE("")
    ) dut (
        .clock(clock),
        .sreset(sreset),
        .address(address),
        .writedata(writedata),
        .read(read),
        .write(write),
        .readdata(readdata),
        .waitrequest(waitrequest),
        .irq(irq)
    );

    // Clock and cycle counter.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Zero-wait write: called and returns at a falling edge.
    task automatic bus_write(input string tag, input logic [11:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        read      = 1'b0;
        #1 check_eq({tag, " wr_wait"}, 32'(waitrequest), 32'd0);
        @(negedge clock);
        write = 1'b0;
    endtask

    // Two-cycle read: stalled in cycle 1, data and accept in cycle 2.
    task automatic bus_read(input string tag, input logic [11:0] a, input logic [31:0] exp);
        address = a;
        read    = 1'b1;
        write   = 1'b0;
        #1 check_eq({tag, " rd_wait1"}, 32'(waitrequest), 32'd1);
        @(negedge clock);
        check_eq({tag, " rd_wait2"}, 32'(waitrequest), 32'd0);
        check_eq({tag, " rd_data"}, readdata, exp);
        @(negedge clock);
        read = 1'b0;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        cyc       = 0;
        sreset    = 1'b1;
        read      = 1'b1;
        write     = 1'b0;
        address   = 12'h004;
        writedata = '0;

        // Reset with a pending read.
        tick(3);
        check_eq("rst readdata", readdata, 32'd0);
        check_eq("rst irq", 32'(irq), 32'd0);
        check_eq("rst wait", 32'(waitrequest), 32'd1);
        sreset = 1'b0;
        #1 check_eq("post rst wait1", 32'(waitrequest), 32'd1);
        @(negedge clock);
        check_eq("post rst wait2", 32'(waitrequest), 32'd0);
        @(negedge clock);
        read = 1'b0;

        // RAM round trip and back-to-back reads.
        bus_write("w3e1", 12'h3E1, 32'h0BADF00D);
        bus_write("w3e0", 12'h3E0, 32'hDEADBEEF);
        bus_read("r3e0 next", 12'h3E0, 32'hDEADBEEF);
        c0 = cyc;
        bus_read("b2b 3e0", 12'h3E0, 32'hDEADBEEF);
        bus_read("b2b 3e1", 12'h3E1, 32'h0BADF00D);
        check_eq("b2b cycles", 32'(cyc - c0), 32'd4);

        // Illegal read+write: write only, no read, readdata held.
        address   = 12'h010;
        writedata = 32'h55;
        read      = 1'b1;
        write     = 1'b1;
        #1 check_eq("rw wait", 32'(waitrequest), 32'd0);
        @(negedge clock);
        read  = 1'b0;
        write = 1'b0;
        check_eq("rw hold", readdata, 32'h0BADF00D);
        bus_read("r010", 12'h010, 32'h55);

        // RAM top boundary and unmapped space.
        bus_write("w7ff", 12'h7FF, 32'hA5A50001);
        bus_read("r7ff", 12'h7FF, 32'hA5A50001);
        bus_read("r800", 12'h800, 32'd0);
        bus_read("re00", 12'hE00, 32'd0);
        bus_write("wf07", 12'hF07, 32'h12345678);
        bus_read("rf07", 12'hF07, 32'd0);

        // Auto-reload timer, period 4.
        bus_write("reload3", A_RELOAD, 32'd3);
        bus_write("count3", A_COUNT, 32'd3);
        bus_read("rd reload", A_RELOAD, 32'd3);
        bus_write("ctrl7", A_CTRL, 32'd7);
        check_eq("auto irq0", 32'(irq), 32'd0);
        tick(4);
        check_eq("auto irq at exp", 32'(irq), 32'd0);
        tick(1);
        check_eq("auto irq on", 32'(irq), 32'd1);
        bus_read("auto count", A_COUNT, 32'd2);
        // This clear lands on the second expiry edge: EXP must survive.
        bus_write("clr collide", A_STATUS, 32'd1);
        bus_read("exp survives", A_STATUS, 32'd1);
        check_eq("irq survives", 32'(irq), 32'd1);
        bus_write("clr", A_STATUS, 32'd1);
        check_eq("irq lag", 32'(irq), 32'd1);
        tick(1);
        check_eq("irq dropped", 32'(irq), 32'd0);
        tick(1);
        check_eq("irq reassert", 32'(irq), 32'd1);

        // One-shot timer.
        bus_write("ctrl0", A_CTRL, 32'd0);
        bus_write("clr2", A_STATUS, 32'd1);
        bus_write("count5", A_COUNT, 32'd5);
        bus_write("ctrl3", A_CTRL, 32'd3);
        check_eq("os irq0", 32'(irq), 32'd0);
        tick(6);
        check_eq("os irq at exp", 32'(irq), 32'd0);
        tick(1);
        check_eq("os irq on", 32'(irq), 32'd1);
        bus_read("os ctrl", A_CTRL, 32'd2);
        bus_read("os count", A_COUNT, 32'd0);
        bus_read("os status", A_STATUS, 32'd1);

        // COUNT write collides with COUNT=0 and EN=1.
        bus_write("clr3", A_STATUS, 32'd1);
        bus_write("count0", A_COUNT, 32'd0);
        bus_write("ctrl1", A_CTRL, 32'd1);
        bus_write("count9", A_COUNT, 32'd9);
        bus_read("cw count", A_COUNT, 32'd9);
        bus_read("cw status", A_STATUS, 32'd0);
        bus_write("ctrl off", A_CTRL, 32'd0);

        tick(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
